// File: rtl/sync_debounce.sv
// sync_debounce: per-channel CDC synchronizer followed by a stability filter.
// A new synchronized level is only accepted once it has been seen for
// STABLE_CYCLES consecutive cycles; acceptance produces a one-cycle RISE or
// FALL pulse that lines up with the first cycle DATA_OUT shows the new level.
module sync_debounce #(
   parameter int                  CHANNELS      = 1,
   parameter int                  FF_DEPTH      = 2,
   parameter int                  STABLE_CYCLES = 4,
   parameter logic [CHANNELS-1:0] RESET_VALUE   = '0
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [CHANNELS-1:0] DATA_IN,
   output logic [CHANNELS-1:0] DATA_OUT,
   output logic [CHANNELS-1:0] RISE,
   output logic [CHANNELS-1:0] FALL,
   output logic                ANY_EVENT
);

   // A one-cycle filter still needs a 1-bit counter so the compare logic is uniform.
   localparam int              CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   (* ASYNC_REG = "TRUE" *) logic [CHANNELS-1:0] sync_q [FF_DEPTH];
   logic [CHANNELS-1:0] sync_d [FF_DEPTH];
   logic [CHANNELS-1:0] sync_s;

   logic [CHANNELS-1:0] data_q, data_d;
   logic [CHANNELS-1:0] rise_q, rise_d;
   logic [CHANNELS-1:0] fall_q, fall_d;
   logic [CNT_W-1:0]    cnt_q [CHANNELS];
   logic [CNT_W-1:0]    cnt_d [CHANNELS];

   // Synchronizer chain: stage 0 samples the raw input, each later stage copies the previous one.
   always_comb begin
      sync_d[0] = DATA_IN;
      for (int k = 1; k < FF_DEPTH; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

   // Synchronizer flops; the last stage is the only one the filter may look at.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int k = 0; k < FF_DEPTH; k++) begin
            sync_q[k] <= RESET_VALUE;
         end
      end else begin
         for (int k = 0; k < FF_DEPTH; k++) begin
            sync_q[k] <= sync_d[k];
         end
      end
   end

   assign sync_s = sync_q[FF_DEPTH-1];

   // Per-channel stability filter: count consecutive mismatches, accept on the last one,
   // and clear the count whenever the synchronized level falls back to the accepted one.
   always_comb begin
      data_d = data_q;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync_s[i] == data_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            data_d[i] = sync_s[i];
            cnt_d[i]  = '0;
            rise_d[i] = sync_s[i];
            fall_d[i] = ~sync_s[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end
      end
   end

   // Filter state and registered edge pulses; reset discards any pending transition.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         data_q <= RESET_VALUE;
         rise_q <= '0;
         fall_q <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         data_q <= data_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign DATA_OUT  = data_q;
   assign RISE      = rise_q;
   assign FALL      = fall_q;
   // Built only from registered pulses so there is no combinational path from DATA_IN.
   assign ANY_EVENT = |(rise_q | fall_q);

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce: a 4-channel filtering instance and a
// 1-channel pass-through (STABLE_CYCLES=1, FF_DEPTH=3) instance share clock and reset.
module tb_sync_debounce;

   logic       clk;
   logic       rst;
   logic [3:0] din_a, dout_a, rise_a, fall_a;
   logic       any_a;
   logic [0:0] din_b, dout_b, rise_b, fall_b;
   logic       any_b;

   int n_tests = 0;
   int n_fail  = 0;

   sync_debounce #(
      .CHANNELS(4), .FF_DEPTH(2), .STABLE_CYCLES(4), .RESET_VALUE(4'b0101)
   ) dut_a (
      .CLK(clk), .RST(rst), .DATA_IN(din_a), .DATA_OUT(dout_a),
      .RISE(rise_a), .FALL(fall_a), .ANY_EVENT(any_a)
   );

   sync_debounce #(
      .CHANNELS(1), .FF_DEPTH(3), .STABLE_CYCLES(1), .RESET_VALUE(1'b0)
   ) dut_b (
      .CLK(clk), .RST(rst), .DATA_IN(din_b), .DATA_OUT(dout_b),
      .RISE(rise_b), .FALL(fall_b), .ANY_EVENT(any_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One rising edge, then settle 1 time unit so outputs are sampled away from the edge.
   task automatic tick(input int n);
      for (int j = 0; j < n; j++) begin
         @(posedge clk);
         #1;
      end
   endtask

   int         ev_cnt;
   int         bad_cnt;
   logic [0:0] hist [64];
   logic [0:0] exp_b, prv_b;

   initial begin
      rst   = 1'b1;
      din_a = 4'b1010;
      din_b = 1'b0;
      #1;
      // Reset holds the reset level regardless of DATA_IN
      check_eq("rst_dout", 64'(dout_a), 64'h5);
      check_eq("rst_any", 64'(any_a), 64'h0);
      for (int r = 0; r < 3; r++) begin
         tick(1);
         check_eq("rst_hold_dout", 64'(dout_a), 64'h5);
         check_eq("rst_hold_rise", 64'(rise_a), 64'h0);
         check_eq("rst_hold_fall", 64'(fall_a), 64'h0);
         check_eq("rst_hold_b", 64'(dout_b), 64'h0);
      end

      // Release with DATA_IN != RESET_VALUE: every channel flips after full latency
      rst = 1'b0;
      tick(5);
      check_eq("rel_edge4_dout", 64'(dout_a), 64'h5);
      check_eq("rel_edge4_any", 64'(any_a), 64'h0);
      tick(1);
      check_eq("rel_edge5_dout", 64'(dout_a), 64'hA);
      check_eq("rel_edge5_rise", 64'(rise_a), 64'hA);
      check_eq("rel_edge5_fall", 64'(fall_a), 64'h5);
      check_eq("rel_edge5_any", 64'(any_a), 64'h1);
      tick(1);
      check_eq("rel_edge6_rise", 64'(rise_a), 64'h0);
      check_eq("rel_edge6_fall", 64'(fall_a), 64'h0);
      check_eq("rel_edge6_any", 64'(any_a), 64'h0);

      // Clean step on ch0
      din_a = 4'b1011;
      tick(5);
      check_eq("step_edge4_dout", 64'(dout_a), 64'hA);
      check_eq("step_edge4_rise", 64'(rise_a), 64'h0);
      tick(1);
      check_eq("step_edge5_dout", 64'(dout_a), 64'hB);
      check_eq("step_edge5_rise", 64'(rise_a), 64'h1);
      check_eq("step_edge5_any", 64'(any_a), 64'h1);
      tick(1);
      check_eq("step_edge6_rise", 64'(rise_a), 64'h0);
      check_eq("step_edge6_any", 64'(any_a), 64'h0);

      // Return ch0 to 0
      din_a = 4'b1010;
      tick(6);
      check_eq("back_fall", 64'(fall_a), 64'h1);
      check_eq("back_dout", 64'(dout_a), 64'hA);
      tick(2);

      // Glitch bursts: 3 cycles high, 1 low, never accepted
      ev_cnt  = 0;
      bad_cnt = 0;
      for (int c = 0; c < 52; c++) begin
         din_a = ((c % 4) < 3) ? 4'b1011 : 4'b1010;
         tick(1);
         if (any_a) ev_cnt++;
         if (dout_a != 4'b1010) bad_cnt++;
      end
      din_a = 4'b1010;
      for (int c = 0; c < 8; c++) begin
         tick(1);
         if (any_a) ev_cnt++;
         if (dout_a != 4'b1010) bad_cnt++;
      end
      check_eq("glitch_events", 64'(ev_cnt), 64'h0);
      check_eq("glitch_dout_bad", 64'(bad_cnt), 64'h0);

      // Simultaneous opposite edges on ch1 and ch2
      din_a = 4'b1100;
      tick(8);
      check_eq("simul_setup", 64'(dout_a), 64'hC);
      din_a = 4'b1010;
      tick(5);
      check_eq("simul_edge4_any", 64'(any_a), 64'h0);
      tick(1);
      check_eq("simul_rise", 64'(rise_a), 64'h2);
      check_eq("simul_fall", 64'(fall_a), 64'h4);
      check_eq("simul_any", 64'(any_a), 64'h1);
      check_eq("simul_dout", 64'(dout_a), 64'hA);
      tick(1);
      check_eq("simul_any_clr", 64'(any_a), 64'h0);

      // Reset in the middle of a pending ch3 transition
      din_a = 4'b0010;
      tick(8);
      check_eq("midrst_setup", 64'(dout_a), 64'h2);
      din_a = 4'b1010;
      tick(4);
      check_eq("midrst_pending", 64'(dout_a), 64'h2);
      rst = 1'b1;
      #1;
      check_eq("midrst_dout", 64'(dout_a), 64'h5);
      check_eq("midrst_rise", 64'(rise_a), 64'h0);
      tick(1);
      rst = 1'b0;
      tick(5);
      check_eq("midrst_edge4_ch3", 64'(dout_a[3]), 64'h0);
      tick(1);
      check_eq("midrst_edge5_dout", 64'(dout_a), 64'hA);
      check_eq("midrst_edge5_rise", 64'(rise_a), 64'hA);

      // STABLE_CYCLES=1, FF_DEPTH=3: output is input delayed by 3 edges
      din_b = 1'b0;
      tick(4);
      for (int k = 0; k < 20; k++) begin
         din_b   = (((k / 2) % 2) == 1) ? 1'b1 : 1'b0;
         hist[k] = din_b;
         tick(1);
         exp_b = (k >= 3) ? hist[k-3] : 1'b0;
         prv_b = (k >= 4) ? hist[k-4] : 1'b0;
         check_eq("pass_dout", 64'(dout_b), 64'(exp_b));
         check_eq("pass_rise", 64'(rise_b), 64'(exp_b & ~prv_b));
         check_eq("pass_fall", 64'(fall_b), 64'(~exp_b & prv_b));
         check_eq("pass_any", 64'(any_b), 64'((exp_b ^ prv_b)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
